// File: rtl/clock_text_pkg.sv
// Shared glyph geometry and character codes for the clock text renderer.
// Combinational helpers only; no state, no latency, no backpressure.
package clock_text_pkg;

  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int STR_LEN = 11;

  localparam logic [6:0] CH_BLANK = 7'h20;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_0     = 7'h30;
  localparam logic [6:0] CH_A     = 7'h41;
  localparam logic [6:0] CH_P     = 7'h50;
  localparam logic [6:0] CH_M     = 7'h4D;

  // A nibble outside 0..9 is not a valid BCD digit, so it renders blank.
  function automatic logic [6:0] bcd_char(input logic [3:0] nib);
    if (nib > 4'd9) return CH_BLANK;
    return CH_0 + {3'b000, nib};
  endfunction

endpackage

// File: rtl/clock_text_charsel.sv
// Maps a character slot of "HH:MM:SS AM/PM" to its 7-bit glyph code.
// Purely combinational, zero latency, never stalls.
import clock_text_pkg::*;

module clock_text_charsel (
  input  logic [3:0] idx_i,
  input  logic [7:0] hr_i,
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic       pm_i,
  input  logic       blink_phase_i,
  output logic [6:0] code_o
);

  always_comb begin
    code_o = CH_BLANK;
    unique case (idx_i)
      // Leading zero of a 12-hour clock is suppressed.
      4'd0:    code_o = (hr_i[7:4] == 4'd0) ? CH_BLANK : bcd_char(hr_i[7:4]);
      4'd1:    code_o = bcd_char(hr_i[3:0]);
      4'd2:    code_o = blink_phase_i ? CH_COLON : CH_BLANK;
      4'd3:    code_o = bcd_char(min_i[7:4]);
      4'd4:    code_o = bcd_char(min_i[3:0]);
      4'd5:    code_o = blink_phase_i ? CH_COLON : CH_BLANK;
      4'd6:    code_o = bcd_char(sec_i[7:4]);
      4'd7:    code_o = bcd_char(sec_i[3:0]);
      4'd9:    code_o = pm_i ? CH_P : CH_A;
      4'd10:   code_o = CH_M;
      default: code_o = CH_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_text_renderer.sv
// Renders "HH:MM:SS AM/PM" from the glyph ROM; pixel to text_on/rgb/syncs = 2 clocks,
// rom_addr lags pixel by 1 clock. One pixel per clock, no backpressure.
import clock_text_pkg::*;

module clock_text_renderer #(
  parameter int          X0           = 64,
  parameter int          Y0           = 32,
  parameter int          SCALE_LOG2   = 0,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_RGB       = 12'hFFF,
  parameter logic [11:0] BG_RGB       = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_tick,
  input  logic [7:0]  hr_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  sec_bcd,
  input  logic        pm,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        text_on,
  output logic [11:0] rgb
);

  localparam logic [9:0] X0_V       = 10'(X0);
  localparam logic [9:0] Y0_V       = 10'(Y0);
  localparam logic [9:0] BOX_W      = 10'((STR_LEN * CHAR_W) << SCALE_LOG2);
  localparam logic [9:0] BOX_H      = 10'(CHAR_H << SCALE_LOG2);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0]  hr_q, min_q, sec_q;
  logic        pm_q;
  logic [7:0]  frame_cnt_q;
  logic        blink_phase_q;

  logic [9:0]  dx, dy;
  logic        in_box;
  logic [3:0]  idx;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [6:0]  code;
  logic [10:0] rom_addr_d, rom_addr_q;

  logic [2:0]  col_d1_q;
  logic        in_box_d1_q, video_d1_q, hs_d1_q, vs_d1_q;

  logic        glyph_bit;
  logic        text_on_d, text_on_q;
  logic [11:0] rgb_d, rgb_q;
  logic        hs_q, vs_q;

  // dx/dy wrap when left of or above the origin; the >= tests mask that case.
  always_comb begin
    dx     = pixel_x - X0_V;
    dy     = pixel_y - Y0_V;
    in_box = (pixel_x >= X0_V) && (dx < BOX_W) && (pixel_y >= Y0_V) && (dy < BOX_H);
    idx    = dx[3+SCALE_LOG2 +: 4];
    col    = dx[SCALE_LOG2 +: 3];
    row    = dy[SCALE_LOG2 +: 4];
  end

  clock_text_charsel u_charsel (
    .idx_i         (idx),
    .hr_i          (hr_q),
    .min_i         (min_q),
    .sec_i         (sec_q),
    .pm_i          (pm_q),
    .blink_phase_i (blink_phase_q),
    .code_o        (code)
  );

  always_comb begin
    rom_addr_d = in_box ? {code, row} : 11'h000;
    glyph_bit  = rom_data[3'd7 - col_d1_q];
    text_on_d  = video_d1_q & in_box_d1_q & glyph_bit;
    rgb_d      = !video_d1_q ? 12'h000 : (text_on_d ? FG_RGB : BG_RGB);
  end

  // Time is sampled once per frame so a frame never shows two different times.
  always_ff @(posedge clk) begin
    if (reset) begin
      hr_q          <= 8'h12;
      min_q         <= 8'h00;
      sec_q         <= 8'h00;
      pm_q          <= 1'b0;
      frame_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
    end else if (frame_tick) begin
      hr_q  <= hr_bcd;
      min_q <= min_bcd;
      sec_q <= sec_bcd;
      pm_q  <= pm;
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_q   <= 8'd0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q  <= 11'h000;
      col_d1_q    <= 3'd0;
      in_box_d1_q <= 1'b0;
      video_d1_q  <= 1'b0;
      hs_d1_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      text_on_q   <= 1'b0;
      rgb_q       <= 12'h000;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      col_d1_q    <= col;
      in_box_d1_q <= in_box;
      video_d1_q  <= video_on;
      hs_d1_q     <= hsync_in;
      vs_d1_q     <= vsync_in;
      text_on_q   <= text_on_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d1_q;
      vs_q        <= vs_d1_q;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign text_on   = text_on_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule
